alarm_buzzer: RTL and testbench

Downstream consumer of the alarm clock's `alarm_o` vector. It merges all alarm channels into a single piezo drive signal. While any alarm is active it plays a repeating beep pattern: groups of square-wave beeps separated by short gaps, with a longer pause between groups. It also exports registered status for LEDs and the display.

---
 rtl/alarm_buzzer_if.sv | 27 ++
 rtl/alarm_buzzer.sv | 127 ++++++++++++
 tb/tb_alarm_buzzer.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alarm_buzzer_if.sv
// Bundles the alarm inputs, mute and buzzer/status outputs of alarm_buzzer.
// The master side drives alarms and mute; the slave side is the buzzer block.
interface alarm_buzzer_if #(
  parameter int ALARMS_CNT = 7
);
  logic [ALARMS_CNT-1:0] alarm_i;
  logic                  mute_i;
  logic                  buzzer_o;
  logic                  active_o;
  logic [ALARMS_CNT-1:0] alarms_q_o;

  modport master (
    output alarm_i,
    output mute_i,
    input  buzzer_o,
    input  active_o,
    input  alarms_q_o
  );

  modport slave (
    input  alarm_i,
    input  mute_i,
    output buzzer_o,
    output active_o,
    output alarms_q_o
  );
endinterface

// File: rtl/alarm_buzzer.sv
// Merges all alarm channels into one piezo drive.
// While any alarm is set, it plays groups of square-wave beeps separated by gaps and a longer pause.
module alarm_buzzer #(
  parameter int ALARMS_CNT      = 7,
  parameter int CLK_FREQ        = 50_000_000,
  parameter int TONE_HZ         = 2000,
  parameter int BEEP_ON_MS      = 200,
  parameter int BEEP_OFF_MS     = 200,
  parameter int BEEPS_PER_GROUP = 4,
  parameter int GROUP_PAUSE_MS  = 800
) (
  input  logic            clk_i,
  input  logic            rst_i,
  alarm_buzzer_if.slave   bus
);

  localparam int HALF      = CLK_FREQ / (2 * TONE_HZ);
  localparam int ON_CYC    = CLK_FREQ / 1000 * BEEP_ON_MS;
  localparam int OFF_CYC   = CLK_FREQ / 1000 * BEEP_OFF_MS;
  localparam int PAUSE_CYC = CLK_FREQ / 1000 * GROUP_PAUSE_MS;
  localparam int MAX_A     = (ON_CYC > OFF_CYC) ? ON_CYC : OFF_CYC;
  localparam int MAX_CYC   = (MAX_A > PAUSE_CYC) ? MAX_A : PAUSE_CYC;
  localparam int PW        = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int TW        = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int IW        = (BEEPS_PER_GROUP > 1) ? $clog2(BEEPS_PER_GROUP) : 1;

  localparam logic [PW-1:0] ON_LOAD    = PW'(ON_CYC - 1);
  localparam logic [PW-1:0] OFF_LOAD   = PW'(OFF_CYC - 1);
  localparam logic [PW-1:0] PAUSE_LOAD = PW'(PAUSE_CYC - 1);
  localparam logic [TW-1:0] TONE_LAST  = TW'(HALF - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(BEEPS_PER_GROUP - 1);

  typedef enum logic [1:0] {IDLE, BEEP, GAP, PAUSE} state_t;

  state_t                state, next_state;
  logic [PW-1:0]         phase, next_phase;
  logic [IW-1:0]         beep_idx, next_beep_idx;
  logic [TW-1:0]         tone_cnt, next_tone_cnt;
  logic                  tone_q, next_tone_q;
  logic [ALARMS_CNT-1:0] alarms_q;
  logic                  buzzer_q;
  logic                  any_q;

  assign any_q          = |alarms_q;
  assign bus.alarms_q_o = alarms_q;
  assign bus.buzzer_o   = buzzer_q;
  assign bus.active_o   = (state != IDLE);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state    <= IDLE;
      phase    <= '0;
      beep_idx <= '0;
      tone_cnt <= '0;
      tone_q   <= 1'b0;
      alarms_q <= '0;
      buzzer_q <= 1'b0;
    end else begin
      state    <= next_state;
      phase    <= next_phase;
      beep_idx <= next_beep_idx;
      tone_cnt <= next_tone_cnt;
      tone_q   <= next_tone_q;
      alarms_q <= bus.alarm_i;
      buzzer_q <= (next_state == BEEP) & next_tone_q & ~bus.mute_i;
    end
  end

  // Losing every alarm wins over phase expiry; every beep restarts its tone high.
  always_comb begin
    next_state    = state;
    next_phase    = phase;
    next_beep_idx = beep_idx;
    next_tone_cnt = tone_cnt;
    next_tone_q   = tone_q;
    if (!any_q) begin
      next_state    = IDLE;
      next_phase    = '0;
      next_beep_idx = '0;
      next_tone_cnt = '0;
      next_tone_q   = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          next_state    = BEEP;
          next_phase    = ON_LOAD;
          next_beep_idx = '0;
          next_tone_cnt = '0;
          next_tone_q   = 1'b1;
        end
        BEEP: begin
          if (tone_cnt == TONE_LAST) begin
            next_tone_cnt = '0;
            next_tone_q   = ~tone_q;
          end else begin
            next_tone_cnt = tone_cnt + TW'(1);
          end
          if (phase == '0) begin
            if (beep_idx == IDX_LAST) begin
              next_state = PAUSE;
              next_phase = PAUSE_LOAD;
            end else begin
              next_state    = GAP;
              next_phase    = OFF_LOAD;
              next_beep_idx = beep_idx + IW'(1);
            end
          end else begin
            next_phase = phase - PW'(1);
          end
        end
        GAP, PAUSE: begin
          if (phase == '0) begin
            next_state    = BEEP;
            next_phase    = ON_LOAD;
            next_tone_cnt = '0;
            next_tone_q   = 1'b1;
            if (state == PAUSE) next_beep_idx = '0;
          end else begin
            next_phase = phase - PW'(1);
          end
        end
        default: next_state = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alarm_buzzer.sv
// Directed bench for alarm_buzzer with a 4-cycle beep, 4-cycle gap, 8-cycle pause, 2 beeps per group.
// The pattern repeats every 20 cycles; buzzer reads 1,1,0,0 for each beep.
module tb_alarm_buzzer;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  alarm_buzzer_if #(.ALARMS_CNT(7)) bus ();

  alarm_buzzer #(
    .ALARMS_CNT(7),
    .CLK_FREQ(4000),
    .TONE_HZ(1000),
    .BEEP_ON_MS(1),
    .BEEP_OFF_MS(1),
    .BEEPS_PER_GROUP(2),
    .GROUP_PAUSE_MS(2)
  ) dut (
    .clk_i(clk),
    .rst_i(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected buzzer level j cycles after entering the first beep of a group.
  function automatic logic exp_buz(input int j);
    int m;
    m = j % 20;
    return (m == 0) || (m == 1) || (m == 8) || (m == 9);
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic go_idle();
    bus.alarm_i = '0;
    bus.mute_i  = 1'b0;
    step(3);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.alarm_i = '0;
    bus.mute_i  = 1'b0;
    #1;
    vectors++;
    if (bus.buzzer_o !== 1'b0 || bus.active_o !== 1'b0 || bus.alarms_q_o !== 7'h00) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs got buz=%b act=%b q=%h want 0 0 00", bus.buzzer_o, bus.active_o, bus.alarms_q_o);
    end
    step(2);
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step(1);
      vectors++;
      if (bus.buzzer_o !== 1'b0 || bus.active_o !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL idle cyc=%0d got buz=%b act=%b want 0 0", i, bus.buzzer_o, bus.active_o);
      end
    end
  endtask

  task automatic test_pattern();
    bus.alarm_i = 7'b0001000;
    step(1);
    vectors++;
    if (bus.alarms_q_o !== 7'b0001000 || bus.active_o !== 1'b0 || bus.buzzer_o !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL start_latency got q=%b act=%b buz=%b want 0001000 0 0", bus.alarms_q_o, bus.active_o, bus.buzzer_o);
    end
    for (int j = 0; j < 48; j++) begin
      step(1);
      vectors++;
      if (bus.active_o !== 1'b1 || bus.buzzer_o !== exp_buz(j)) begin
        miscompares++;
        $display("[TB] FAIL pattern j=%0d got act=%b buz=%b want 1 %b", j, bus.active_o, bus.buzzer_o, exp_buz(j));
      end
    end
    bus.alarm_i = '0;
    step(2);
    vectors++;
    if (bus.active_o !== 1'b0 || bus.buzzer_o !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL stop_after_pattern got act=%b buz=%b want 0 0", bus.active_o, bus.buzzer_o);
    end
  endtask

  task automatic test_stop_mid_beep();
    go_idle();
    bus.alarm_i = 7'b0000100;
    step(1);
    for (int j = 0; j <= 8; j++) begin
      step(1);
      vectors++;
      if (bus.buzzer_o !== exp_buz(j)) begin
        miscompares++;
        $display("[TB] FAIL stop_pre j=%0d got buz=%b want %b", j, bus.buzzer_o, exp_buz(j));
      end
    end
    bus.alarm_i = '0;
    step(1);
    vectors++;
    if (bus.active_o !== 1'b1 || bus.buzzer_o !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL stop_edge1 got act=%b buz=%b want 1 1", bus.active_o, bus.buzzer_o);
    end
    step(1);
    vectors++;
    if (bus.active_o !== 1'b0 || bus.buzzer_o !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL stop_edge2 got act=%b buz=%b want 0 0", bus.active_o, bus.buzzer_o);
    end
    bus.alarm_i = 7'b0000100;
    step(1);
    vectors++;
    if (bus.active_o !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL restart_latency got act=%b want 0", bus.active_o);
    end
    for (int j = 0; j < 12; j++) begin
      step(1);
      vectors++;
      if (bus.active_o !== 1'b1 || bus.buzzer_o !== exp_buz(j)) begin
        miscompares++;
        $display("[TB] FAIL restart j=%0d got act=%b buz=%b want 1 %b", j, bus.active_o, bus.buzzer_o, exp_buz(j));
      end
    end
  endtask

  task automatic test_mute();
    go_idle();
    bus.mute_i  = 1'b1;
    bus.alarm_i = 7'b0000010;
    step(1);
    for (int j = 0; j < 30; j++) begin
      step(1);
      if (j == 20) begin
        vectors++;
        if (bus.buzzer_o !== 1'b0 || bus.active_o !== 1'b1) begin
          miscompares++;
          $display("[TB] FAIL mute_release_edge got buz=%b act=%b want 0 1", bus.buzzer_o, bus.active_o);
        end
        bus.mute_i = 1'b0;
      end else if (j < 20) begin
        vectors++;
        if (bus.buzzer_o !== 1'b0 || bus.active_o !== 1'b1) begin
          miscompares++;
          $display("[TB] FAIL muted j=%0d got buz=%b act=%b want 0 1", j, bus.buzzer_o, bus.active_o);
        end
      end else begin
        vectors++;
        if (bus.buzzer_o !== exp_buz(j)) begin
          miscompares++;
          $display("[TB] FAIL unmuted j=%0d got buz=%b want %b", j, bus.buzzer_o, exp_buz(j));
        end
      end
    end
  endtask

  task automatic test_multi_alarm();
    go_idle();
    bus.alarm_i = 7'b0000001;
    step(1);
    vectors++;
    if (bus.alarms_q_o !== 7'b0000001) begin
      miscompares++;
      $display("[TB] FAIL multi_q0 got %b want 0000001", bus.alarms_q_o);
    end
    for (int j = 0; j < 31; j++) begin
      step(1);
      vectors++;
      if (bus.active_o !== 1'b1 || bus.buzzer_o !== exp_buz(j)) begin
        miscompares++;
        $display("[TB] FAIL multi j=%0d got act=%b buz=%b want 1 %b", j, bus.active_o, bus.buzzer_o, exp_buz(j));
      end
      if (j == 6) begin
        vectors++;
        if (bus.alarms_q_o !== 7'b0100001) begin
          miscompares++;
          $display("[TB] FAIL multi_q_add got %b want 0100001", bus.alarms_q_o);
        end
      end
      if (j == 13) begin
        vectors++;
        if (bus.alarms_q_o !== 7'b0100000) begin
          miscompares++;
          $display("[TB] FAIL multi_q_drop got %b want 0100000", bus.alarms_q_o);
        end
      end
      if (j == 5)  bus.alarm_i = 7'b0100001;
      if (j == 12) bus.alarm_i = 7'b0100000;
    end
    bus.alarm_i = '0;
    step(1);
    vectors++;
    if (bus.alarms_q_o !== 7'b0000000 || bus.active_o !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL multi_stop1 got q=%b act=%b want 0000000 1", bus.alarms_q_o, bus.active_o);
    end
    step(1);
    vectors++;
    if (bus.active_o !== 1'b0 || bus.buzzer_o !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL multi_stop2 got act=%b buz=%b want 0 0", bus.active_o, bus.buzzer_o);
    end
  endtask

  task automatic test_async_reset();
    go_idle();
    bus.alarm_i = 7'b1000000;
    step(1);
    for (int j = 0; j <= 14; j++) step(1);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.buzzer_o !== 1'b0 || bus.active_o !== 1'b0 || bus.alarms_q_o !== 7'h00) begin
      miscompares++;
      $display("[TB] FAIL async_reset got buz=%b act=%b q=%h want 0 0 00", bus.buzzer_o, bus.active_o, bus.alarms_q_o);
    end
    #1 rst_n = 1'b1;
    step(1);
    vectors++;
    if (bus.active_o !== 1'b0 || bus.alarms_q_o !== 7'b1000000) begin
      miscompares++;
      $display("[TB] FAIL post_reset_edge1 got act=%b q=%b want 0 1000000", bus.active_o, bus.alarms_q_o);
    end
    for (int j = 0; j < 12; j++) begin
      step(1);
      vectors++;
      if (bus.active_o !== 1'b1 || bus.buzzer_o !== exp_buz(j)) begin
        miscompares++;
        $display("[TB] FAIL post_reset j=%0d got act=%b buz=%b want 1 %b", j, bus.active_o, bus.buzzer_o, exp_buz(j));
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_pattern();
    test_stop_mid_beep();
    test_mute();
    test_multi_alarm();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
